// File: rtl/param_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : param_mac_pipe
//  Description : Pipelined signed multiply-accumulate.
//                Samples are captured into input registers, multiplied at
//                full precision through MULT_STAGES register stages, and
//                then added into an ACC_W-bit accumulator. The result f is
//                updated MULT_STAGES+1 edges after capture.
//                Accumulation either wraps (SAT_EN=0) or clamps (SAT_EN=1).
//                A sticky overflow flag and a saturating term counter are
//                maintained. Both are restarted by a clear sample.
//  Ports       : clk       - clock, all state changes on the rising edge
//                reset     - synchronous, active-low reset
//                a, b      - signed IN_W-bit operands
//                valid_in  - a/b/clear_in carry a sample this cycle
//                clear_in  - the sample starts a new accumulation
//                f         - signed ACC_W-bit accumulator value
//                valid_out - one-cycle pulse after each accumulator update
//                overflow  - sticky accumulation-overflow flag
//                count     - terms accumulated since the last clear
//  Revision    : 1.0 - initial release
// ============================================================================
module param_mac_pipe #(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 16,
    parameter int MULT_STAGES = 2,
    parameter int SAT_EN      = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    input  logic             clear_in,
    output logic [ACC_W-1:0] f,
    output logic             valid_out,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam int               c_prod_w  = 2 * IN_W;
    localparam logic [ACC_W-1:0] c_sat_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_sat_min = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Elaboration-time guards on illegal parameter combinations.
    generate
        if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
            $error("param_mac_pipe: ACC_W must be at least 2*IN_W");
        end
        if (MULT_STAGES < 1 || MULT_STAGES > 6) begin : g_bad_stages
            $error("param_mac_pipe: MULT_STAGES must be in 1..6");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic signed [IN_W-1:0] r_a;
    logic signed [IN_W-1:0] r_b;
    logic                   r_vld_in;
    logic                   r_clr_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_vld_in <= 1'b0;
            r_clr_in <= 1'b0;
        end else begin
            r_a      <= a;
            r_b      <= b;
            r_vld_in <= valid_in;
            r_clr_in <= clear_in;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier pipeline: stage 0 registers the product, later stages
    // only delay it. Valid/clear travel alongside so they line up with
    // the product at the accumulator.
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] w_a_ext;
    logic signed [c_prod_w-1:0] w_b_ext;
    logic signed [c_prod_w-1:0] r_prod [MULT_STAGES];
    logic                       r_vld  [MULT_STAGES];
    logic                       r_clr  [MULT_STAGES];

    assign w_a_ext = c_prod_w'(r_a);
    assign w_b_ext = c_prod_w'(r_b);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MULT_STAGES; i++) begin
                r_prod[i] <= '0;
                r_vld[i]  <= 1'b0;
                r_clr[i]  <= 1'b0;
            end
        end else begin
            r_prod[0] <= w_a_ext * w_b_ext;
            r_vld[0]  <= r_vld_in;
            r_clr[0]  <= r_clr_in;
            for (int i = 1; i < MULT_STAGES; i++) begin
                r_prod[i] <= r_prod[i-1];
                r_vld[i]  <= r_vld[i-1];
                r_clr[i]  <= r_clr[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_f;
    logic                    r_ovf;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_vout;

    logic                    w_vld_last;
    logic                    w_clr_last;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_f_next;

    assign w_vld_last = r_vld[MULT_STAGES-1];
    assign w_clr_last = r_clr[MULT_STAGES-1];
    assign w_prod_ext = ACC_W'(r_prod[MULT_STAGES-1]);
    assign w_sum      = r_f + w_prod_ext;

    // Two's-complement overflow: addends agree in sign, result does not.
    // A clear sample loads the product alone and cannot overflow.
    assign w_ovf = !w_clr_last
                && (r_f[ACC_W-1] == w_prod_ext[ACC_W-1])
                && (w_sum[ACC_W-1] != r_f[ACC_W-1]);

    always_comb begin
        w_f_next = w_sum;
        if (w_clr_last) begin
            w_f_next = w_prod_ext;
        end else if (w_ovf && (SAT_EN != 0)) begin
            // Overflow direction follows the (shared) sign of the addends.
            w_f_next = r_f[ACC_W-1] ? c_sat_min : c_sat_max;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_f    <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
            r_vout <= 1'b0;
        end else begin
            r_vout <= w_vld_last;
            if (w_vld_last) begin
                r_f <= w_f_next;
                if (w_clr_last) begin
                    r_ovf <= 1'b0;
                    r_cnt <= CNT_W'(1);
                end else begin
                    r_ovf <= r_ovf | w_ovf;
                    if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign f         = r_f;
    assign valid_out = r_vout;
    assign overflow  = r_ovf;
    assign count     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_param_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_mac_pipe
//  Description : Self-checking bench for param_mac_pipe. One wrapping and
//                one saturating instance share the same stimulus. Both are
//                compared every cycle against an arithmetic reference model
//                that holds in-flight samples in a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_mac_pipe;

    localparam int IN_W    = 8;
    localparam int ACC_W   = 16;
    localparam int MS      = 2;
    localparam int CNT_W   = 8;
    localparam int LAT     = MS + 1;
    localparam int F_MAX   = 32767;
    localparam int F_MIN   = -32768;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic             valid_in;
    logic             clear_in;
    logic [ACC_W-1:0] f0, f1;
    logic             vo0, vo1;
    logic             ov0, ov1;
    logic [CNT_W-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    param_mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(MS),
                     .SAT_EN(0), .CNT_W(CNT_W)) u_wrap (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_in(clear_in),
        .f(f0), .valid_out(vo0), .overflow(ov0), .count(cnt0)
    );

    param_mac_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .MULT_STAGES(MS),
                     .SAT_EN(1), .CNT_W(CNT_W)) u_sat (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_in(clear_in),
        .f(f1), .valid_out(vo1), .overflow(ov1), .count(cnt1)
    );

    // ------------------------------------------------------------------
    // Reference model: index 0 = wrapping, index 1 = saturating
    // ------------------------------------------------------------------
    typedef struct {
        int pa;
        int pb;
        bit clr;
        int due;
    } sample_t;

    sample_t q[$];
    int      mf   [2];
    bit      mov  [2];
    int      mcnt [2];
    bit      mvo;
    int      cyc       = 0;
    int      n_err     = 0;
    int      n_chk     = 0;
    int      vo_pulses = 0;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < 2; i++) begin
            mf[i]   = 0;
            mov[i]  = 1'b0;
            mcnt[i] = 0;
        end
        mvo = 1'b0;
    endfunction

    function automatic void model_apply(int pa, int pb, bit clr);
        int prod;
        int sum;
        prod = pa * pb;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                mf[i]   = prod;
                mov[i]  = 1'b0;
                mcnt[i] = 1;
            end else begin
                sum = mf[i] + prod;
                if (sum > F_MAX || sum < F_MIN) begin
                    mov[i] = 1'b1;
                    if (i == 1) mf[i] = (sum > F_MAX) ? F_MAX : F_MIN;
                    else        mf[i] = (sum > F_MAX) ? sum - 65536 : sum + 65536;
                end else begin
                    mf[i] = sum;
                end
                if (mcnt[i] < CNT_MAX) mcnt[i]++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // compare all outputs of both instances 1 time unit after the edge.
    task automatic step(input int ia, input int ib, input bit iv,
                        input bit ic, input bit irst);
        a        = 8'(ia);
        b        = 8'(ib);
        valid_in = iv;
        clear_in = ic;
        reset    = irst;
        @(posedge clk);
        cyc++;
        if (!irst) begin
            model_reset();
        end else begin
            mvo = 1'b0;
            while (q.size() > 0 && q[0].due == cyc) begin
                model_apply(q[0].pa, q[0].pb, q[0].clr);
                mvo = 1'b1;
                void'(q.pop_front());
            end
            if (iv) begin
                q.push_back('{pa: int'($signed(8'(ia))), pb: int'($signed(8'(ib))),
                              clr: ic, due: cyc + LAT});
            end
        end
        #1;
        check("wrap.f",         $signed(f0), mf[0]);
        check("wrap.valid_out", vo0,         mvo);
        check("wrap.overflow",  ov0,         mov[0]);
        check("wrap.count",     cnt0,        mcnt[0]);
        check("sat.f",          $signed(f1), mf[1]);
        check("sat.valid_out",  vo1,         mvo);
        check("sat.overflow",   ov1,         mov[1]);
        check("sat.count",      cnt1,        mcnt[1]);
        vo_pulses += int'(vo0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset held for two edges under random inputs.
        repeat (2) step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        1'($urandom), 1'($urandom), 1'b0);
        check("reset.f",        $signed(f0), 0);
        check("reset.overflow", ov1,         0);
        check("reset.count",    cnt0,        0);

        // Basic accumulation and latency.
        vo_pulses = 0;
        step(2, 2, 1'b1, 1'b1, 1'b1);
        idle(1);
        step(3, 3, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("basic.f_first", $signed(f0), 4);
        idle(1);
        check("basic.f_hold", $signed(f0), 4);
        idle(1);
        check("basic.f_second", $signed(f0), 13);
        idle(3);
        check("basic.pulses", vo_pulses, 2);
        check("basic.count",  cnt0,      2);

        // Positive overflow: wrap vs. clamp.
        step(127, 127, 1'b1, 1'b1, 1'b1);
        step(127, 127, 1'b1, 1'b0, 1'b1);
        step(127, 127, 1'b1, 1'b0, 1'b1);
        step(1,   1,   1'b1, 1'b0, 1'b1);
        idle(2);
        check("wrap.f_ovf",   $signed(f0), -17149);
        check("wrap.ovf_set", ov0,         1);
        check("sat.f_clamp",  $signed(f1), 32767);
        idle(1);
        check("wrap.f_after", $signed(f0), -17148);
        check("wrap.ovf_sticky", ov0, 1);
        idle(2);

        // Clamped value keeps accumulating.
        step(127, 127, 1'b1, 1'b1, 1'b1);
        step(127, 127, 1'b1, 1'b0, 1'b1);
        step(127, 127, 1'b1, 1'b0, 1'b1);
        step(-128, 127, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("sat.f_after",   $signed(f1), 16511);
        check("sat.ovf_sticky", ov1,        1);
        check("wrap.f_neg_add", $signed(f0), 32131);

        // Clear after overflow.
        step(-3, 5, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("clear.f",        $signed(f0), -15);
        check("clear.overflow", ov0,         0);
        check("clear.count",    cnt1,        1);

        // Reset while three samples are in flight.
        step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
        step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
        step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        vo_pulses = 0;
        idle(5);
        check("midrst.pulses", vo_pulses,  0);
        check("midrst.f",      $signed(f0), 0);
        step(4, 4, 1'b1, 1'b0, 1'b1);
        idle(3);
        check("midrst.f_next", $signed(f0), 16);
        check("midrst.count",  cnt0,        1);

        // Term counter saturation.
        step(1, 1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 299; i++)
            step(int'($urandom_range(0, 3)), 1, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("cnt.sat_wrap", cnt0, 255);
        check("cnt.sat_sat",  cnt1, 255);

        // Random traffic with extreme operands and occasional reset.
        for (int i = 0; i < 400; i++) begin
            int ra;
            int rb;
            ra = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : 128)
                                             : int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : 128)
                                             : int'($urandom_range(0, 255));
            step(ra, rb, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 99) != 0));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_mac_pipe.md
PARAM_MAC_PIPE -- requirements
Module: param_mac_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 8, the signed operand width.
REQ-002 The block SHALL have parameter ACC_W, default 16, the signed accumulator width; legal only if ACC_W >= 2*IN_W.
REQ-003 The block SHALL have parameter MULT_STAGES, default 2, the multiplier pipeline depth; legal range 1..6.
REQ-004 The block SHALL have parameter SAT_EN, default 0: 0 selects wrap-around accumulation, 1 selects saturating accumulation.
REQ-005 The block SHALL have parameter CNT_W, default 8, the term-counter width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port a, input, IN_W bits: signed operand.
REQ-009 The block SHALL have port b, input, IN_W bits: signed operand.
REQ-010 The block SHALL have port valid_in, input, 1 bit: a/b/clear_in are a sample this cycle.
REQ-011 The block SHALL have port clear_in, input, 1 bit: this sample starts a new accumulation.
REQ-012 The block SHALL have port f, output, ACC_W bits: signed accumulator value.
REQ-013 The block SHALL have port valid_out, output, 1 bit: f updated by a valid sample on the previous edge.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky accumulation-overflow flag.
REQ-015 The block SHALL have port count, output, CNT_W bits: terms accumulated since last clear.

Function
REQ-016 The block SHALL capture a, b, valid_in, clear_in into input registers on every rising edge.
REQ-017 The block SHALL form the full-precision signed product a*b (2*IN_W bits) through exactly MULT_STAGES register stages, with valid and clear flags delayed alongside.
REQ-018 The block SHALL update f exactly MULT_STAGES+1 edges after the edge at which the sample was captured (latency L = MULT_STAGES+1).
REQ-019 The block SHALL accept one sample per cycle with no bubbles; back-to-back valid_in is legal indefinitely.
REQ-020 Samples with valid_in=0 SHALL NOT alter f, overflow or count; clear_in with valid_in=0 is ignored.
REQ-021 The block SHALL sign-extend the product to ACC_W and compute f_next = f + product (normal) or f_next = product (clear sample).
REQ-022 The block SHALL detect overflow when both addends share a sign and the ACC_W-bit result sign differs; a clear sample never overflows.
REQ-023 With SAT_EN=0, on overflow f SHALL take the wrapped ACC_W-bit sum.
REQ-024 With SAT_EN=1, on overflow f SHALL clamp to 2^(ACC_W-1)-1 (positive) or -2^(ACC_W-1) (negative); later terms add to the clamped value.
REQ-025 overflow SHALL set on the update edge of the overflowing sample and remain 1 until a clear sample is accumulated or reset.
REQ-026 A clear sample SHALL set overflow to 0 and count to 1; simultaneous clear and overflow is impossible by REQ-022.
REQ-027 count SHALL increment by 1 per accumulated valid sample and saturate at 2^CNT_W-1.
REQ-028 valid_out SHALL be 1 for exactly one cycle following each accumulator update, else 0.

Reset
REQ-029 While reset=0 at a rising edge, all pipeline registers, delayed valid/clear flags, f, count, overflow and valid_out SHALL become 0.
REQ-030 Samples in flight when reset is asserted SHALL be discarded; no valid_out is produced for them after reset releases.
REQ-031 The first sample after reset SHALL accumulate onto f=0 whether or not clear_in is set.

Verification (IN_W=8, ACC_W=16, MULT_STAGES=2, CNT_W=8)
REQ-032 Reset: reset=0 for 2 edges with random inputs -> f=0, valid_out=0, overflow=0, count=0.
REQ-033 Basic/latency: (2,2,clear=1), idle cycle, (3,3) -> f=4 three edges after first capture, f=13 three edges after second; valid_out pulses twice; f holds across the idle cycle; count=2.
REQ-034 Wrap: SAT_EN=0, (127,127,clear), (127,127), (127,127), (1,1) -> f=16129, 32258, -17149 with overflow=1, then -17148 with overflow still 1.
REQ-035 Saturate: SAT_EN=1, same first three samples, then (-128,127) -> f=16129, 32258, 32767 with overflow=1, then 16511 with overflow still 1.
REQ-036 Clear after overflow: following REQ-034, (-3,5,clear=1) -> f=-15, overflow=0, count=1.
REQ-037 Reset mid-pipeline: three back-to-back valid samples, reset=0 for one edge one cycle after the last capture -> f=0, no valid_out pulses afterwards, next sample (4,4) gives f=16.
